// File: rtl/cte_yuv_pkg.sv
// Shared definitions for the CTE RGB -> YUV 4:2:2 transmit path.
package cte_yuv_pkg;

  // BT.601 full-range coefficients, scaled by 256
  localparam logic signed [17:0] Y_R = 18'sd77;
  localparam logic signed [17:0] Y_G = 18'sd150;
  localparam logic signed [17:0] Y_B = 18'sd29;
  localparam logic signed [17:0] U_R = -18'sd43;
  localparam logic signed [17:0] U_G = -18'sd85;
  localparam logic signed [17:0] U_B = 18'sd128;
  localparam logic signed [17:0] V_R = 18'sd128;
  localparam logic signed [17:0] V_G = -18'sd107;
  localparam logic signed [17:0] V_B = -18'sd21;

  // Byte tags on the serial link
  localparam logic [1:0] OUT_SEL_U  = 2'd0;
  localparam logic [1:0] OUT_SEL_Y0 = 2'd1;
  localparam logic [1:0] OUT_SEL_V  = 2'd2;
  localparam logic [1:0] OUT_SEL_Y1 = 2'd3;

  typedef enum logic [2:0] {IDLE, S_U, S_Y0, S_V, S_Y1} tx_state_t;

  // One serialized group; 33 bits wide in the FIFO
  typedef struct packed {
    logic       last;
    logic [7:0] u;
    logic [7:0] y0;
    logic [7:0] v;
    logic [7:0] y1;
  } grp_t;

  function automatic logic [7:0] clamp_u8(input logic signed [17:0] x);
    if (x < 0)              return 8'd0;
    else if (x > 18'sd255)  return 8'd255;
    else                    return x[7:0];
  endfunction

  // Two's complement result in the low byte
  function automatic logic [7:0] clamp_s8(input logic signed [17:0] x);
    if (x < -18'sd128)      return 8'h80;
    else if (x > 18'sd127)  return 8'h7f;
    else                    return x[7:0];
  endfunction

endpackage

// File: rtl/rgb2yuv_pix.sv
// Two-stage stallable per-pixel RGB -> YCbCr converter with valid/ready on both sides.
module rgb2yuv_pix
  import cte_yuv_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] rgb_in,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  y,
  output logic [7:0]  u,
  output logic [7:0]  v,
  output logic        out_last
);

  localparam int PROD_W = 18;

  function automatic logic signed [PROD_W-1:0] round_shift(input logic signed [PROD_W-1:0] s);
    return (s + 18'sd128) >>> 8;
  endfunction

  logic signed [PROD_W-1:0] r_s, g_s, b_s;
  logic                     vld_p1, vld_p2, rdy_p1, rdy_p2;
  logic                     last_p1, last_p2;
  logic signed [PROD_W-1:0] yr_p1, yg_p1, yb_p1;
  logic signed [PROD_W-1:0] ur_p1, ug_p1, ub_p1;
  logic signed [PROD_W-1:0] vr_p1, vg_p1, vb_p1;
  logic [7:0]               y_p2, u_p2, v_p2;

  assign r_s = $signed({10'd0, rgb_in[23:16]});
  assign g_s = $signed({10'd0, rgb_in[15:8]});
  assign b_s = $signed({10'd0, rgb_in[7:0]});

  // A stage advances when it is empty or the next stage takes its data
  assign rdy_p2   = !vld_p2 || out_ready;
  assign rdy_p1   = !vld_p1 || rdy_p2;
  assign in_ready = rdy_p1;

  // Stage valids
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (rdy_p1) vld_p1 <= in_valid;
      if (rdy_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: coefficient products ----
  always_ff @(posedge clk) begin
    if (rdy_p1 && in_valid) begin
      yr_p1   <= r_s * Y_R;
      yg_p1   <= g_s * Y_G;
      yb_p1   <= b_s * Y_B;
      ur_p1   <= r_s * U_R;
      ug_p1   <= g_s * U_G;
      ub_p1   <= b_s * U_B;
      vr_p1   <= r_s * V_R;
      vg_p1   <= g_s * V_G;
      vb_p1   <= b_s * V_B;
      last_p1 <= in_last;
    end
  end

  // ---- stage 2: sum, round, clamp ----
  always_ff @(posedge clk) begin
    if (rdy_p2 && vld_p1) begin
      y_p2    <= clamp_u8(round_shift(yr_p1 + yg_p1 + yb_p1));
      u_p2    <= clamp_s8(round_shift(ur_p1 + ug_p1 + ub_p1));
      v_p2    <= clamp_s8(round_shift(vr_p1 + vg_p1 + vb_p1));
      last_p2 <= last_p1;
    end
  end

  assign out_valid = vld_p2;
  assign y         = y_p2;
  assign u         = u_p2;
  assign v         = v_p2;
  assign out_last  = last_p2;

endmodule

// File: rtl/rgb_to_yuv422_tx.sv
// CTE link transmitter: RGB pixels in, U/Y0/V/Y1 byte stream out.
module rgb_to_yuv422_tx
  import cte_yuv_pkg::*;
#(
  parameter int GRP_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] rgb_in,
  input  logic        in_last,
  output logic [7:0]  dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_sel,
  output logic        out_last
);

  localparam int AW = $clog2(GRP_FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(GRP_FIFO_DEPTH);

  logic       init_done, pix_in_ready;
  logic       pix_vld, pix_ready, pix_last;
  logic [7:0] pix_y, pix_u, pix_v;

  // in_ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) init_done <= 1'b0;
    else       init_done <= 1'b1;
  end

  assign in_ready = init_done && pix_in_ready;

  rgb2yuv_pix u_pix (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid && init_done),
    .in_ready  (pix_in_ready),
    .rgb_in    (rgb_in),
    .in_last   (in_last),
    .out_valid (pix_vld),
    .out_ready (pix_ready),
    .y         (pix_y),
    .u         (pix_u),
    .v         (pix_v),
    .out_last  (pix_last)
  );

  // ---- pair collector ----
  logic             has_p0, closes_grp, push, pop, push_ok, fifo_full, fifo_empty;
  logic [7:0]       y0_h, u0_h, v0_h;
  logic signed [8:0] u_sum, v_sum;
  grp_t             grp_in, fifo_head, cur_grp;

  assign u_sum      = $signed({u0_h[7], u0_h}) + $signed({pix_u[7], pix_u});
  assign v_sum      = $signed({v0_h[7], v0_h}) + $signed({pix_v[7], pix_v});
  assign closes_grp = has_p0 || pix_last;
  assign push_ok    = !fifo_full || pop;
  assign pix_ready  = !closes_grp || push_ok;
  assign push       = pix_vld && closes_grp && push_ok;

  // Form a paired group, or a lone group for an odd line end
  always_comb begin
    grp_in = '0;
    if (has_p0) grp_in = '{last: pix_last, u: u_sum[8:1], y0: y0_h, v: v_sum[8:1], y1: pix_y};
    else        grp_in = '{last: 1'b1, u: pix_u, y0: pix_y, v: pix_v, y1: pix_y};
  end

  // Pair phase; cleared after every completed group
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        has_p0 <= 1'b0;
    else if (pix_vld && pix_ready)    has_p0 <= !has_p0 && !pix_last;
  end

  // Hold pixel 0 of a pair
  always_ff @(posedge clk) begin
    if (pix_vld && !has_p0 && !pix_last) begin
      y0_h <= pix_y;
      u0_h <= pix_u;
      v0_h <= pix_v;
    end
  end

  // ---- group FIFO ----
  grp_t          mem [GRP_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign fifo_head  = mem[rd_ptr];

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= grp_in;
  end

  // ---- serializer FSM ----
  tx_state_t state, state_nx;

  assign pop = !fifo_empty && ((state == IDLE) || (state == S_Y1 && out_ready));

  // State and current-group registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cur_grp <= '0;
    end else begin
      state <= state_nx;
      if (pop) cur_grp <= fifo_head;
    end
  end

  // Next state: advance on each accepted byte, chain groups without a bubble
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!fifo_empty) state_nx = S_U;
      S_U:  if (out_ready)   state_nx = S_Y0;
      S_Y0: if (out_ready)   state_nx = S_V;
      S_V:  if (out_ready)   state_nx = S_Y1;
      S_Y1: if (out_ready)   state_nx = fifo_empty ? IDLE : S_U;
      default:               state_nx = IDLE;
    endcase
  end

  // Byte outputs decoded from state and the held group
  always_comb begin
    out_valid = 1'b0;
    dout      = 8'd0;
    out_sel   = OUT_SEL_U;
    out_last  = 1'b0;
    unique case (state)
      S_U:  begin out_valid = 1'b1; dout = cur_grp.u;  out_sel = OUT_SEL_U;  end
      S_Y0: begin out_valid = 1'b1; dout = cur_grp.y0; out_sel = OUT_SEL_Y0; end
      S_V:  begin out_valid = 1'b1; dout = cur_grp.v;  out_sel = OUT_SEL_V;  end
      S_Y1: begin out_valid = 1'b1; dout = cur_grp.y1; out_sel = OUT_SEL_Y1; out_last = cur_grp.last; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rgb_to_yuv422_tx.sv
// Self-checking bench for rgb_to_yuv422_tx with an arithmetic reference model.
module tb_rgb_to_yuv422_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [23:0] rgb_in = '0;
  logic        in_ready, out_valid, out_last;
  logic [7:0]  dout;
  logic [1:0]  out_sel;

  int n_cmp = 0, n_bad = 0;
  int rdy_mode = 1;
  int stall_left = 0;
  logic track_block = 1'b0, saw_block = 1'b0;

  // entries are {sel, last, byte}
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];

  rgb_to_yuv422_tx #(.GRP_FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .rgb_in(rgb_in), .in_last(in_last), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_has0 = 0, m_y0, m_u0, m_v0;

  function automatic int clampi(int x, int lo, int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic void push_grp(int u, int y0, int v, int y1, logic lst);
    logic [7:0] b;
    b = u[7:0];  exp_q.push_back({2'd0, 1'b0, b});
    b = y0[7:0]; exp_q.push_back({2'd1, 1'b0, b});
    b = v[7:0];  exp_q.push_back({2'd2, 1'b0, b});
    b = y1[7:0]; exp_q.push_back({2'd3, lst, b});
  endfunction

  function automatic void model_pixel(logic [23:0] px, logic lst);
    int r, g, b, y, u, v;
    r = px[23:16]; g = px[15:8]; b = px[7:0];
    y = clampi((77*r + 150*g + 29*b + 128) >>> 8, 0, 255);
    u = clampi((-43*r - 85*g + 128*b + 128) >>> 8, -128, 127);
    v = clampi((128*r - 107*g - 21*b + 128) >>> 8, -128, 127);
    if (m_has0 == 0) begin
      if (lst) push_grp(u, y, v, y, 1'b1);
      else begin m_has0 = 1; m_y0 = y; m_u0 = u; m_v0 = v; end
    end else begin
      push_grp((m_u0 + u) >>> 1, m_y0, (m_v0 + v) >>> 1, y, lst);
      m_has0 = 0;
    end
  endfunction

  always @(negedge rstn) begin
    exp_q.delete();
    m_has0 = 0;
  end

  // ---------------- compare process ----------------
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [10:0] prev_b = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_v = 1'b0;
    end else begin
      if (in_valid && in_ready) model_pixel(rgb_in, in_last);
      if (track_block && in_valid && !in_ready) saw_block = 1'b1;
      if (prev_v && !prev_r) begin
        n_cmp++;
        if (!out_valid || {out_sel, out_last, dout} !== prev_b) begin
          n_bad++;
          $display("FAIL hold_stable: got v=%0b %h required v=1 %h", out_valid, {out_sel, out_last, dout}, prev_b);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: got %h required no byte", {out_sel, out_last, dout});
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          if ({out_sel, out_last, dout} !== e) begin
            n_bad++;
            $display("FAIL stream_byte: got sel=%0d last=%0b dout=%h required sel=%0d last=%0b dout=%h",
                     out_sel, out_last, dout, e[10:9], e[8], e[7:0]);
          end
        end
        got_q.push_back({out_sel, out_last, dout});
      end
      prev_v = out_valid; prev_r = out_ready; prev_b = {out_sel, out_last, dout};
    end
  end

  // ---------------- downstream ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 2) out_ready = 1'b0;
    else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
    else if ($urandom_range(0, 9) == 0) begin out_ready = 1'b0; stall_left = 4; end
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Caller must be just after a rising edge
  task automatic send_pix(input logic [23:0] px, input logic lst);
    int w; logic acc;
    rgb_in = px; in_last = lst; in_valid = 1'b1; w = 0;
    do begin
      @(negedge clk); acc = in_ready; w++;
      @(posedge clk); #1;
    end while (!acc && w < 300);
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles required 1", w);
    end
  endtask

  task automatic wait_bytes(input int n);
    int w; w = 0;
    while (got_q.size() < n && w < 300) begin @(negedge clk); w++; end
    if (got_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_timeout: got %0d bytes required %0d", got_q.size(), n);
    end
  endtask

  task automatic check_grp(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic lst);
    logic [7:0]  bv[4];
    logic [10:0] e;
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
    for (int i = 0; i < 4; i++) begin
      e = {2'(i), (i == 3) && lst, bv[i]};
      n_cmp++;
      if (got_q.size() <= i) begin
        n_bad++;
        $display("FAIL %s[%0d]: got nothing required %h", nm, i, e);
      end else if (got_q[i] !== e) begin
        n_bad++;
        $display("FAIL %s[%0d]: got %h required %h", nm, i, got_q[i], e);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, w;
    logic [23:0] px;

    // 1. reset holds everything quiet
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; rgb_in = 24'($urandom); in_last = ~in_last;
      @(negedge clk);
      check("rst_outs", {22'd0, out_valid, out_sel, out_last, dout}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0; rdy_mode = 0;
    @(negedge clk); rstn = 1'b1; #1;
    check("rel_in_ready_same", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_in_ready_next", {31'd0, in_ready}, 32'd1);

    // 2. white pair and latency
    got_q.delete();
    send_pix(24'hFFFFFF, 1'b0);
    send_pix(24'hFFFFFF, 1'b0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    check("u_latency", lat, 4);
    wait_bytes(4);
    check_grp("white", 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0);

    // 3. red then blue
    @(posedge clk); #1; got_q.delete();
    send_pix(24'hFF0000, 1'b0);
    send_pix(24'h0000FF, 1'b0);
    wait_bytes(4);
    check_grp("red_blue", 8'h2A, 8'h4D, 8'h35, 8'h1D, 1'b0);

    // 4. odd line end, then a fresh pair
    @(posedge clk); #1; got_q.delete();
    send_pix(24'hFF0000, 1'b1);
    wait_bytes(4);
    check_grp("odd_end", 8'hD5, 8'h4D, 8'h7F, 8'h4D, 1'b1);
    @(posedge clk); #1; got_q.delete();
    send_pix(24'hFF0000, 1'b0);
    send_pix(24'h0000FF, 1'b0);
    wait_bytes(4);
    check_grp("after_odd", 8'h2A, 8'h4D, 8'h35, 8'h1D, 1'b0);

    // 5. random stream under random backpressure
    @(posedge clk); #1;
    saw_block = 1'b0; track_block = 1'b1; rdy_mode = 2;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          px = 24'($urandom);
          send_pix(px, (i == 15) ? 1'b1 : ($urandom_range(0, 4) == 0));
        end
      end
      begin
        repeat (24) @(posedge clk);
        rdy_mode = 1;
      end
    join
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin @(negedge clk); w++; end
    check("rand_drained", exp_q.size(), 0);
    check("rand_in_ready_fell", {31'd0, saw_block}, 32'd1);
    track_block = 1'b0; rdy_mode = 0;

    // 6. reset mid-group
    @(posedge clk); #1; got_q.delete();
    send_pix(24'hFF0000, 1'b0);
    send_pix(24'h0000FF, 1'b0);
    wait_bytes(1);
    #2; rstn = 1'b0; #1;
    check("midrst_outs", {22'd0, out_valid, out_sel, out_last, dout}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1; got_q.delete();
    send_pix(24'hFFFFFF, 1'b0);
    send_pix(24'hFF0000, 1'b0);
    wait_bytes(4);
    check_grp("post_rst", 8'hEA, 8'hFF, 8'h3F, 8'h4D, 1'b0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
